// File: rtl/mcs40_clk_gen_multi.sv
// MCS-40 two-phase clock generator with programmable period/windows, run/stop control and subcycle counter.
// Optional single-step input step_i is enabled by defining MCS40_CLK_SINGLESTEP_EN.
module mcs40_clk_gen_multi #(
    parameter int PERIOD     = 7,
    parameter int CNT_W      = 8,
    parameter int PHI1_START = 0,
    parameter int PHI1_WIDTH = 2,
    parameter int PHI2_START = 4,
    parameter int PHI2_WIDTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       run_i,
`ifdef MCS40_CLK_SINGLESTEP_EN
    input  logic       step_i,
`endif
    output logic       PHI1_o,
    output logic       PHI2_o,
    output logic       SYNC_o,
    output logic       running_o,
    output logic       tick_o,
    output logic [2:0] subcycle_o
);

    if (PERIOD < 4 || PERIOD > 255) begin : g_err_period
        $error("mcs40_clk_gen_multi: PERIOD must be in 4..255");
    end
    if (CNT_W < 1 || CNT_W > 30 || (1 << CNT_W) < PERIOD) begin : g_err_cnt_w
        $error("mcs40_clk_gen_multi: CNT_W too narrow for PERIOD");
    end
    if (PHI1_WIDTH < 1 || PHI1_START < 0 || PHI1_START + PHI1_WIDTH > PERIOD) begin : g_err_phi1
        $error("mcs40_clk_gen_multi: PHI1 window out of range");
    end
    if (PHI2_WIDTH < 1 || PHI2_START < 0 || PHI2_START + PHI2_WIDTH > PERIOD) begin : g_err_phi2
        $error("mcs40_clk_gen_multi: PHI2 window out of range");
    end
    if (PHI1_START < PHI2_START + PHI2_WIDTH && PHI2_START < PHI1_START + PHI1_WIDTH) begin : g_err_overlap
        $error("mcs40_clk_gen_multi: PHI1 and PHI2 windows overlap");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W:0]   P1_LO    = (CNT_W + 1)'(PHI1_START);
    localparam logic [CNT_W:0]   P1_W     = (CNT_W + 1)'(PHI1_WIDTH);
    localparam logic [CNT_W:0]   P2_LO    = (CNT_W + 1)'(PHI2_START);
    localparam logic [CNT_W:0]   P2_W     = (CNT_W + 1)'(PHI2_WIDTH);

    // Window test via unsigned offset: counts below the start wrap to a large value and fail the compare.
    function automatic logic in_window(input logic [CNT_W-1:0] c,
                                       input logic [CNT_W:0]   lo,
                                       input logic [CNT_W:0]   w);
        logic [CNT_W:0] off;
        off = {1'b0, c} - lo;
        return off < w;
    endfunction

    state_t           state_p0;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_p0;
    logic [CNT_W-1:0] cnt_nxt;
    logic             step_req;
    logic             wrap;
    logic             active;

`ifdef MCS40_CLK_SINGLESTEP_EN
    assign step_req = step_i;
`else
    assign step_req = 1'b0;
`endif

    assign wrap   = (cnt_p0 == CNT_LAST);
    assign active = (state_p0 != ST_IDLE);

    always_comb begin
        state_nxt = state_p0;
        cnt_nxt   = cnt_p0;
        case (state_p0)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (run_i) begin
                    state_nxt = ST_RUN;
                end else if (step_req) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_RUN: begin
                cnt_nxt = wrap ? '0 : cnt_p0 + 1'b1;
                if (!run_i) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                cnt_nxt = wrap ? '0 : cnt_p0 + 1'b1;
                if (run_i) begin
                    state_nxt = ST_RUN;
                end else if (wrap) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Stage p0 -> outputs: every output is a registered function of the current cnt/state.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_p0   <= ST_IDLE;
            cnt_p0     <= '0;
            PHI1_o     <= 1'b1;
            PHI2_o     <= 1'b1;
            SYNC_o     <= 1'b1;
            running_o  <= 1'b0;
            tick_o     <= 1'b0;
            subcycle_o <= 3'd0;
        end else begin
            state_p0  <= state_nxt;
            cnt_p0    <= cnt_nxt;
            PHI1_o    <= !(active && in_window(cnt_p0, P1_LO, P1_W));
            PHI2_o    <= !(active && in_window(cnt_p0, P2_LO, P2_W));
            SYNC_o    <= !(active && subcycle_o == 3'd7);
            running_o <= active;
            tick_o    <= active && wrap;
            if (active && wrap) begin
                subcycle_o <= subcycle_o + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_mcs40_clk_gen_multi.sv
// Randomized and directed bench for mcs40_clk_gen_multi against a period-level behavioural model.
module tb_mcs40_clk_gen_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       run   = 1'b0;
    logic       step  = 1'b0;
    logic       a_phi1, a_phi2, a_sync, a_run, a_tick;
    logic [2:0] a_sub;
    logic       b_phi1, b_phi2, b_sync, b_run, b_tick;
    logic [2:0] b_sub;
    logic [7:0] obs_a, obs_b;

    int total  = 0;
    int passed = 0;

    assign obs_a = {a_phi1, a_phi2, a_sync, a_run, a_tick, a_sub};
    assign obs_b = {b_phi1, b_phi2, b_sync, b_run, b_tick, b_sub};

    mcs40_clk_gen_multi u_a (
        .clk_i(clk), .rst_n_i(rst_n), .run_i(run),
`ifdef MCS40_CLK_SINGLESTEP_EN
        .step_i(step),
`endif
        .PHI1_o(a_phi1), .PHI2_o(a_phi2), .SYNC_o(a_sync),
        .running_o(a_run), .tick_o(a_tick), .subcycle_o(a_sub)
    );

    mcs40_clk_gen_multi #(
        .PERIOD(10), .CNT_W(4), .PHI1_START(1), .PHI1_WIDTH(3), .PHI2_START(6), .PHI2_WIDTH(3)
    ) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .run_i(run),
`ifdef MCS40_CLK_SINGLESTEP_EN
        .step_i(step),
`endif
        .PHI1_o(b_phi1), .PHI2_o(b_phi2), .SYNC_o(b_sync),
        .running_o(b_run), .tick_o(b_tick), .subcycle_o(b_sub)
    );

    // Model: generator is either idle or inside a period at position pos; stp means "finish this period then stop".
    typedef struct {
        bit act;
        bit stp;
        int pos;
        int sub;
        bit phi1, phi2, sync, running, tick;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_reset();
        mdl_t n;
        n.act = 0; n.stp = 0; n.pos = 0; n.sub = 0;
        n.phi1 = 1; n.phi2 = 1; n.sync = 1; n.running = 0; n.tick = 0;
        return n;
    endfunction

    function automatic mdl_t mdl_next(mdl_t m, bit rn, bit rq, bit sq,
                                      int per, int s1, int w1, int s2, int w2);
        mdl_t n = m;
        if (!rn) return mdl_reset();
        n.phi1    = !(m.act && m.pos >= s1 && m.pos < s1 + w1);
        n.phi2    = !(m.act && m.pos >= s2 && m.pos < s2 + w2);
        n.tick    = m.act && (m.pos == per - 1);
        n.running = m.act;
        n.sync    = !(m.act && m.sub == 7);
        if (!m.act) begin
            if (rq) begin
                n.act = 1; n.stp = 0; n.pos = 0;
            end else if (sq) begin
                n.act = 1; n.stp = 1; n.pos = 0;
            end
        end else begin
            if (m.pos == per - 1) n.sub = (m.sub + 1) % 8;
            if (!rq && m.stp && m.pos == per - 1) begin
                n.act = 0; n.stp = 0; n.pos = 0;
            end else begin
                n.stp = !rq;
                n.pos = (m.pos + 1) % per;
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] exp_vec(mdl_t m);
        return {m.phi1, m.phi2, m.sync, m.running, m.tick, 3'(m.sub)};
    endfunction

    task automatic step_clk();
        @(posedge clk);
        ma = mdl_next(ma, rst_n, run, step, 7, 0, 2, 4, 2);
        mb = mdl_next(mb, rst_n, run, step, 10, 1, 3, 6, 3);
        #1;
    endtask

    always @(negedge clk) begin
        total++;
        if ((a_phi1 === 1'b0 && a_phi2 === 1'b0) || (b_phi1 === 1'b0 && b_phi2 === 1'b0))
            $display("FAIL nonoverlap: a=%b%b b=%b%b, required never both 0", a_phi1, a_phi2, b_phi1, b_phi2);
        else
            passed++;
    end

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; step = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_clk();
            total += 2;
            if (obs_a !== 8'b1110_0000) $display("FAIL reset_a: got %b want %b", obs_a, 8'b1110_0000);
            else passed++;
            if (obs_b !== 8'b1110_0000) $display("FAIL reset_b: got %b want %b", obs_b, 8'b1110_0000);
            else passed++;
        end
    endtask

    task automatic test_default_waveform();
        int last_tick = -1;
        int last_sub  = -1;
        int p1 = 0, p2 = 0, sy = 0, q1 = 0;
        rst_n = 1'b1; run = 1'b1;
        for (int i = 0; i < 70; i++) begin
            step_clk();
            total += 2;
            if (obs_a !== exp_vec(ma)) $display("FAIL wave_a cyc %0d: got %b want %b", i, obs_a, exp_vec(ma));
            else passed++;
            if (obs_b !== exp_vec(mb)) $display("FAIL wave_b cyc %0d: got %b want %b", i, obs_b, exp_vec(mb));
            else passed++;
            if (a_tick === 1'b1) begin
                if (last_tick >= 0) begin
                    total += 2;
                    if (i - last_tick != 7) $display("FAIL tick_period: got %0d want 7", i - last_tick);
                    else passed++;
                    if (int'(a_sub) != (last_sub + 1) % 8) $display("FAIL sub_step: got %0d want %0d", a_sub, (last_sub + 1) % 8);
                    else passed++;
                end
                last_tick = i;
                last_sub  = int'(a_sub);
            end
            if (a_phi1 === 1'b0) p1++;
            else if (p1 > 0) begin
                total++;
                if (p1 != 2) $display("FAIL phi1_len: got %0d want 2", p1);
                else passed++;
                p1 = 0;
            end
            if (a_phi2 === 1'b0) p2++;
            else if (p2 > 0) begin
                total++;
                if (p2 != 2) $display("FAIL phi2_len: got %0d want 2", p2);
                else passed++;
                p2 = 0;
            end
            if (a_sync === 1'b0) sy++;
            else if (sy > 0) begin
                total++;
                if (sy != 7) $display("FAIL sync_len: got %0d want 7", sy);
                else passed++;
                sy = 0;
            end
            if (b_phi1 === 1'b0) q1++;
            else if (q1 > 0) begin
                total++;
                if (q1 != 3) $display("FAIL b_phi1_len: got %0d want 3", q1);
                else passed++;
                q1 = 0;
            end
        end
    endtask

    task automatic wait_pos(input int p, input string tag);
        int n = 0;
        while (!(ma.act && ma.pos == p) && n < 40) begin
            step_clk();
            n++;
        end
        if (n >= 40) begin
            total++;
            $display("FAIL %s_timeout: got pos %0d want %0d", tag, ma.pos, p);
        end
    endtask

    task automatic test_stop();
        int ticks = 0;
        logic [2:0] held;
        run = 1'b1;
        wait_pos(2, "stop");
        run = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step_clk();
            total++;
            if (obs_a !== exp_vec(ma)) $display("FAIL stop_a cyc %0d: got %b want %b", i, obs_a, exp_vec(ma));
            else passed++;
            if (a_tick === 1'b1) ticks++;
        end
        total += 2;
        if (ticks != 1) $display("FAIL stop_ticks: got %0d want 1", ticks);
        else passed++;
        if (a_run !== 1'b0) $display("FAIL stop_running: got %b want 0", a_run);
        else passed++;
        held = a_sub;
        for (int i = 0; i < 5; i++) begin
            step_clk();
            total++;
            if ({a_phi1, a_phi2, a_sync, a_sub} !== {3'b111, held})
                $display("FAIL idle_hold: got %b want %b", {a_phi1, a_phi2, a_sync, a_sub}, {3'b111, held});
            else passed++;
        end
    endtask

    task automatic test_resume();
        run = 1'b1;
        wait_pos(2, "resume");
        run = 1'b0;
        step_clk();
        wait_pos(4, "resume4");
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step_clk();
            total += 2;
            if (a_run !== 1'b1) $display("FAIL resume_running cyc %0d: got %b want 1", i, a_run);
            else passed++;
            if (obs_a !== exp_vec(ma)) $display("FAIL resume_a cyc %0d: got %b want %b", i, obs_a, exp_vec(ma));
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        run = 1'b1;
        while (!(ma.act && ma.sub == 5 && ma.pos == 3) && n < 200) begin
            step_clk();
            n++;
        end
        total += 2;
        if (a_sub !== 3'd5) $display("FAIL midrst_pre: got sub %0d want 5", a_sub);
        else passed++;
        rst_n = 1'b0;
        step_clk();
        if (obs_a !== 8'b1110_0000) $display("FAIL midrst_a: got %b want %b", obs_a, 8'b1110_0000);
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(9) == 0) run = ~run;
            rst_n = ($urandom_range(99) != 0);
`ifdef MCS40_CLK_SINGLESTEP_EN
            step = ($urandom_range(7) == 0);
`endif
            step_clk();
            total += 2;
            if (obs_a !== exp_vec(ma)) $display("FAIL rand_a cyc %0d: got %b want %b", i, obs_a, exp_vec(ma));
            else passed++;
            if (obs_b !== exp_vec(mb)) $display("FAIL rand_b cyc %0d: got %b want %b", i, obs_b, exp_vec(mb));
            else passed++;
        end
        rst_n = 1'b1; step = 1'b0;
    endtask

`ifdef MCS40_CLK_SINGLESTEP_EN
    task automatic test_single_step();
        int ticks = 0, runs = 0, n = 0;
        logic [2:0] sub0;
        run = 1'b0; step = 1'b0;
        while (ma.act && n < 40) begin
            step_clk();
            n++;
        end
        step_clk();
        sub0 = a_sub;
        step = 1'b1;
        step_clk();
        step = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step_clk();
            if (a_tick === 1'b1) ticks++;
            if (a_run === 1'b1) runs++;
        end
        total += 4;
        if (ticks != 1) $display("FAIL step_ticks: got %0d want 1", ticks);
        else passed++;
        if (runs != 7) $display("FAIL step_len: got %0d want 7", runs);
        else passed++;
        if (a_sub !== sub0 + 3'd1) $display("FAIL step_sub: got %0d want %0d", a_sub, sub0 + 3'd1);
        else passed++;
        if (a_run !== 1'b0) $display("FAIL step_idle: got %b want 0", a_run);
        else passed++;
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step = (i == 10);
            step_clk();
            total++;
            if (obs_a !== exp_vec(ma)) $display("FAIL step_run_a cyc %0d: got %b want %b", i, obs_a, exp_vec(ma));
            else passed++;
        end
        step = 1'b0;
    endtask
`endif

    initial begin
        ma = mdl_reset();
        mb = mdl_reset();
        test_reset();
        test_default_waveform();
        test_stop();
        test_resume();
        test_reset_mid();
`ifdef MCS40_CLK_SINGLESTEP_EN
        test_single_step();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mcs40_clk_gen_multi.md
Name: mcs40_clk_gen_multi

Overview:
- Parametrised successor to the fixed 7-state MCS-40 two-phase clock generator.
- Generates non-overlapping, active-low PHI1/PHI2 with programmable period and phase windows.
- Adds run/stop control that always finishes a full period before stopping, an 8-subcycle instruction counter, and an active-low SYNC output.
- Sits at the top of the MCS-40 core and drives the 4004/4040 phase inputs and SYNC.

Parameters:
- PERIOD, 7: clk_i cycles per phase period; legal range 4..255.
- CNT_W, 8: width of the period counter; must satisfy 2^CNT_W >= PERIOD.
- PHI1_START, 0: counter value at which the PHI1 low window begins.
- PHI1_WIDTH, 2: PHI1 low window length, in clk_i cycles.
- PHI2_START, 4: counter value at which the PHI2 low window begins.
- PHI2_WIDTH, 2: PHI2 low window length, in clk_i cycles.
- Legality: each window must satisfy START+WIDTH <= PERIOD, WIDTH >= 1, and the windows must not overlap. Violations raise a simulation $error at elaboration.

Ports:
- clk_i, input, 1: main design clock (not a pin).
- rst_n_i, input, 1: synchronous, active-low reset.
- run_i, input, 1: level-sensitive run request.
- PHI1_o, output, 1: phase 1 clock, active low.
- PHI2_o, output, 1: phase 2 clock, active low.
- SYNC_o, output, 1: instruction-cycle sync, active low.
- running_o, output, 1: high while the generator is producing phases.
- tick_o, output, 1: one-cycle pulse on the last counter state of each running period.
- subcycle_o, output, 3: current subcycle index, 0=A1 .. 7=X3.

Behaviour:
- Reset applies when rst_n_i=0 at a clk_i edge, and overrides every other input.
  - Reset values: cnt=0, state=IDLE, PHI1_o=1, PHI2_o=1, SYNC_o=1, running_o=0, tick_o=0, subcycle_o=0.
  - Reset mid-period aborts immediately; no period completion.
- States:
  - IDLE: cnt is held at 0; phase and SYNC outputs are held high.
    - If run_i=1 (or step, see Optional Feature), go to RUN next cycle with cnt=0.
  - RUN: cnt increments by one each cycle and wraps PERIOD-1 -> 0.
    - If run_i=0 is sampled at any cycle, go to STOPPING.
  - STOPPING: cnt keeps counting to PERIOD-1, then the state goes to IDLE and cnt goes to 0.
    - If run_i reasserts before the wrap, return to RUN with no break in phase output.
- All outputs are registered. Each output at cycle t+1 is a function of cnt and state at cycle t, giving 1-cycle latency.
  - PHI1_o = 0 iff state != IDLE and PHI1_START <= cnt < PHI1_START+PHI1_WIDTH; otherwise 1.
  - PHI2_o follows the same rule with the PHI2 parameters.
  - tick_o = 1 iff state != IDLE and cnt == PERIOD-1.
  - running_o = 1 iff state != IDLE.
- Defaults reproduce the legacy waveform exactly: PHI1 low at cnt 0-1, PHI2 low at cnt 4-5, period 7.
- subcycle_o:
  - Increments modulo 8 at each period wrap (the cycle after tick_o's source state).
  - Holds its value in IDLE.
  - Is not cleared by stop/restart; only reset clears it.
- SYNC_o is low for the entire period in which subcycle_o == 7, and high otherwise (always high in IDLE).
- Arithmetic:
  - cnt is CNT_W bits and unsigned.
  - The wrap compare is against PERIOD-1 truncated to CNT_W.
  - subcycle_o is 3 bits and wraps 7 -> 0 naturally.
- Non-overlap is guaranteed structurally: PHI1_o and PHI2_o are never both 0 in the same cycle.

Optional Feature:
- Macro MCS40_CLK_SINGLESTEP_EN.
- Defined: adds input step_i (1 bit), placed after run_i.
  - In IDLE, step_i=1 enters STOPPING directly, producing exactly one full period, one tick_o and one subcycle advance, then returns to IDLE.
  - step_i is ignored outside IDLE.
  - run_i=1 takes priority over step_i.
- Undefined: the step_i port does not exist and the logic is removed.

Test Plan:
- Defaults, rst_n_i=0 for 3 cycles, then run_i=1 for 70 cycles:
  - All outputs hold reset values during reset.
  - After reset, PHI1_o low in 2 of every 7 cycles and PHI2_o low in 2 of 7, separated by 2 high cycles.
  - tick_o has period 7; subcycle_o counts 0..7 then wraps to 0; SYNC_o is low for the 7 cycles of subcycle 7.
- PERIOD=10, PHI1_START=1, PHI1_WIDTH=3, PHI2_START=6, PHI2_WIDTH=3, run_i=1:
  - PHI1_o low for counter states 1-3 and PHI2_o low for states 6-8; period is 10.
  - The two phases are never low together (checked by assertion).
- Drop run_i at cnt=2 of a running period:
  - Phases continue until cnt=6; tick_o pulses once.
  - running_o falls 1 cycle after that wrap; outputs then stay high and subcycle_o holds.
- Drop run_i at cnt=2, reassert at cnt=4:
  - No gap in the waveform and no IDLE entry; running_o stays 1.
- Assert rst_n_i=0 at cnt=3 with subcycle_o=5:
  - Next cycle: all outputs at reset values, subcycle_o=0, PHI1_o=PHI2_o=1.
- With MCS40_CLK_SINGLESTEP_EN, in IDLE pulse step_i for 1 cycle:
  - Exactly one 7-cycle period; one tick_o; subcycle_o advances by 1; return to IDLE.
  - A step_i pulse while running has no effect.
